// File: rtl/atrover_io_bus.sv
// atrover_io_bus: IO half of the rover SoC data bus. Decodes word addresses into
// scratch, LED, button/switch, UART FIFO, RGB PWM and interrupt registers.
module atrover_io_bus #(
  parameter int CLK_FREQ   = 100000000,
  parameter int PWM_FREQ   = 20000,
  parameter int N_LEDS     = 4,
  parameter int N_BTNS     = 4,
  parameter int N_SW       = 4,
  parameter int N_RGB      = 2,
  parameter int FIFO_DEPTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  input  logic               cmd_wr,
  input  logic [5:0]         cmd_addr,
  input  logic [31:0]        cmd_wdata,
  input  logic [3:0]         cmd_be,
  output logic               rsp_valid,
  output logic [31:0]        rsp_data,
  input  logic [N_BTNS-1:0]  btn,
  input  logic [N_SW-1:0]    sw,
  output logic [N_LEDS-1:0]  leds,
  output logic [3*N_RGB-1:0] rgb,
  output logic [7:0]         uart_tx_data,
  output logic               uart_tx_valid,
  input  logic               uart_tx_ready,
  input  logic [7:0]         uart_rx_data,
  input  logic               uart_rx_valid,
  output logic               irq
);
  localparam int PERIOD = CLK_FREQ / PWM_FREQ;
  localparam int CNT_W  = $clog2(PERIOD);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]      FULL_LVL = (AW+1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

  function automatic logic [31:0] be_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                           input logic [3:0] be);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  logic [31:0]       scratch_q, scratch_d;
  logic [N_LEDS-1:0] leds_q, leds_d;
  logic [2:0]        irq_en_q, irq_en_d;
  logic [N_BTNS-1:0] btn_evt_q, btn_evt_d, btn_q, btn_edge;
  logic              tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d;
  logic [2:0]        color_q [N_RGB];
  logic [2:0]        color_d [N_RGB];
  logic [15:0]       dcyc_q [N_RGB];
  logic [15:0]       dcyc_d [N_RGB];
  logic              armed_q, irq_q, rsp_valid_q;
  logic [31:0]       rsp_data_q, rdata;
  logic [CNT_W-1:0]  cnt_q;
  logic [N_RGB-1:0]  pwm;

  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
  logic [AW:0]   tx_lvl_q, rx_lvl_q;
  logic          tx_empty, tx_full, tx_wr, tx_pop, tx_push;
  logic          rx_empty, rx_full, rx_pop, rx_push;

  assign tx_empty = (tx_lvl_q == '0);
  assign tx_full  = (tx_lvl_q == FULL_LVL);
  assign rx_empty = (rx_lvl_q == '0);
  assign rx_full  = (rx_lvl_q == FULL_LVL);
  // A full FIFO still accepts a push when it is popped in the same cycle.
  assign tx_wr    = cmd_valid & cmd_wr & (cmd_addr == 6'd1);
  assign tx_pop   = ~tx_empty & uart_tx_ready;
  assign tx_push  = tx_wr & (~tx_full | tx_pop);
  assign rx_pop   = cmd_valid & ~cmd_wr & (cmd_addr == 6'd2) & ~rx_empty;
  assign rx_push  = uart_rx_valid & (~rx_full | rx_pop);
  // Edges are ignored for one cycle after reset so a button held through reset is not an event.
  assign btn_edge = btn & ~btn_q & {N_BTNS{armed_q}};

  assign leds          = leds_q;
  assign irq           = irq_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign uart_tx_valid = ~tx_empty;
  assign uart_tx_data  = tx_mem[tx_rp_q];

  // Next state of CPU-visible registers: writes, W1C clears, then sticky sets (sets win)
  always_comb begin
    scratch_d = scratch_q;
    leds_d    = leds_q;
    irq_en_d  = irq_en_q;
    color_d   = color_q;
    dcyc_d    = dcyc_q;
    tx_ovf_d  = tx_ovf_q;
    rx_ovf_d  = rx_ovf_q;
    btn_evt_d = btn_evt_q;
    if (cmd_valid && cmd_wr) begin
      case (cmd_addr)
        6'd0: scratch_d = be_merge(scratch_q, cmd_wdata, cmd_be);
        6'd3: begin
          tx_ovf_d = tx_ovf_q & ~cmd_wdata[5];
          rx_ovf_d = rx_ovf_q & ~cmd_wdata[4];
        end
        6'd4: begin
          for (int i = 0; i < N_LEDS; i++) begin
            if (cmd_be[i/8]) leds_d[i] = cmd_wdata[i];
          end
        end
        6'd5: btn_evt_d = btn_evt_q & ~cmd_wdata[N_BTNS-1:0];
        6'd7: if (cmd_be[0]) irq_en_d = cmd_wdata[2:0];
        default: begin
          for (int k = 0; k < N_RGB; k++) begin
            if (cmd_addr == 6'(8 + 2*k) && cmd_be[0]) color_d[k] = cmd_wdata[2:0];
            if (cmd_addr == 6'(9 + 2*k)) begin
              if (cmd_be[0]) dcyc_d[k][7:0]  = cmd_wdata[7:0];
              if (cmd_be[1]) dcyc_d[k][15:8] = cmd_wdata[15:8];
            end
          end
        end
      endcase
    end
    if (tx_wr && !tx_push) tx_ovf_d = 1'b1;
    if (uart_rx_valid && !rx_push) rx_ovf_d = 1'b1;
    btn_evt_d = btn_evt_d | btn_edge;
  end

  // Read mux: reflects state before the command's own side effects
  always_comb begin
    rdata = '0;
    case (cmd_addr)
      6'd0: rdata = scratch_q;
      6'd1: rdata[AW:0] = tx_lvl_q;
      6'd2: if (!rx_empty) rdata = {1'b1, 23'b0, rx_mem[rx_rp_q]};
      6'd3: rdata[5:0] = {tx_ovf_q, rx_ovf_q, rx_full, rx_empty, tx_full, tx_empty};
      6'd4: rdata[N_LEDS-1:0] = leds_q;
      6'd5: rdata[N_BTNS-1:0] = btn_evt_q;
      6'd6: begin
        rdata[16 +: N_SW]   = sw;
        rdata[N_BTNS-1:0]   = btn;
      end
      6'd7: rdata[2:0] = irq_en_q;
      default: begin
        for (int k = 0; k < N_RGB; k++) begin
          if (cmd_addr == 6'(8 + 2*k)) rdata[2:0]  = color_q[k];
          if (cmd_addr == 6'(9 + 2*k)) rdata[15:0] = dcyc_q[k];
        end
      end
    endcase
  end

  // Shared PWM compare and colour gating
  always_comb begin
    pwm = '0;
    rgb = '0;
    for (int k = 0; k < N_RGB; k++) begin
      pwm[k]        = 32'(cnt_q) < 32'(dcyc_q[k]);
      rgb[3*k +: 3] = color_q[k] & {3{pwm[k]}};
    end
  end

  // FIFO storage; contents are meaningless once the pointers are reset
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp_q] <= cmd_wdata[7:0];
    if (rx_push) rx_mem[rx_wp_q] <= uart_rx_data;
  end

  // Control and register state
  always_ff @(posedge clk) begin
    if (reset) begin
      scratch_q   <= '0;
      leds_q      <= '0;
      irq_en_q    <= '0;
      btn_evt_q   <= '0;
      btn_q       <= '0;
      tx_ovf_q    <= 1'b0;
      rx_ovf_q    <= 1'b0;
      armed_q     <= 1'b0;
      irq_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      cnt_q       <= '0;
      tx_wp_q     <= '0;
      tx_rp_q     <= '0;
      tx_lvl_q    <= '0;
      rx_wp_q     <= '0;
      rx_rp_q     <= '0;
      rx_lvl_q    <= '0;
      for (int k = 0; k < N_RGB; k++) begin
        color_q[k] <= '0;
        dcyc_q[k]  <= '0;
      end
    end else begin
      scratch_q   <= scratch_d;
      leds_q      <= leds_d;
      irq_en_q    <= irq_en_d;
      btn_evt_q   <= btn_evt_d;
      btn_q       <= btn;
      tx_ovf_q    <= tx_ovf_d;
      rx_ovf_q    <= rx_ovf_d;
      color_q     <= color_d;
      dcyc_q      <= dcyc_d;
      armed_q     <= 1'b1;
      irq_q       <= |({~rx_empty, tx_empty, |btn_evt_q} & irq_en_q);
      rsp_valid_q <= cmd_valid & ~cmd_wr;
      if (cmd_valid && !cmd_wr) rsp_data_q <= rdata;
      cnt_q       <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
      if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
      tx_lvl_q    <= tx_lvl_q + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
      if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
      if (rx_pop)  rx_rp_q <= rx_rp_q + 1'b1;
      rx_lvl_q    <= rx_lvl_q + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
    end
  end
endmodule

// File: tb/tb_atrover_io_bus.sv
// Testbench for atrover_io_bus: directed scenarios plus randomized traffic,
// all checked cycle by cycle against a queue-based behavioural model.
module tb_atrover_io_bus;
  localparam int PER   = 32;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset, cmd_valid, cmd_wr;
  logic [5:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_be;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [3:0]  btn, sw, leds;
  logic [5:0]  rgb;
  logic [7:0]  uart_tx_data, uart_rx_data;
  logic        uart_tx_valid, uart_tx_ready, uart_rx_valid, irq;

  atrover_io_bus #(
    .CLK_FREQ(640000), .PWM_FREQ(20000), .N_LEDS(4), .N_BTNS(4), .N_SW(4),
    .N_RGB(2), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_be(cmd_be),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .btn(btn), .sw(sw), .leds(leds),
    .rgb(rgb), .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid),
    .uart_tx_ready(uart_tx_ready), .uart_rx_data(uart_rx_data),
    .uart_rx_valid(uart_rx_valid), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_scratch, m_rsp_d;
  logic [3:0]  m_leds, m_evt, m_btn_prev;
  logic [2:0]  m_irq_en;
  logic [2:0]  m_color [2];
  logic [15:0] m_dcyc [2];
  logic        m_txovf, m_rxovf, m_irq, m_rsp_v;
  int          m_cnt;
  logic [7:0]  txq[$];
  logic [7:0]  rxq[$];

  function automatic logic [31:0] merge32(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [5:0] a);
    logic [31:0] v;
    v = '0;
    case (a)
      6'd0: v = m_scratch;
      6'd1: v = 32'(txq.size());
      6'd2: if (rxq.size() > 0) v = {1'b1, 23'b0, rxq[0]};
      6'd3: v = {26'b0, m_txovf, m_rxovf, rxq.size() == DEPTH, rxq.size() == 0,
                 txq.size() == DEPTH, txq.size() == 0};
      6'd4: v = {28'b0, m_leds};
      6'd5: v = {28'b0, m_evt};
      6'd6: v = {12'b0, sw, 12'b0, btn};
      6'd7: v = {29'b0, m_irq_en};
      6'd8, 6'd10: v = {29'b0, m_color[(int'(a) - 8) / 2]};
      6'd9, 6'd11: v = {16'b0, m_dcyc[(int'(a) - 9) / 2]};
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic model_edge();
    logic [31:0] t;
    logic        push_req;
    int          k;
    if (reset) begin
      m_scratch = '0; m_leds = '0; m_evt = '0; m_irq_en = '0;
      m_color[0] = '0; m_color[1] = '0; m_dcyc[0] = '0; m_dcyc[1] = '0;
      m_txovf = 1'b0; m_rxovf = 1'b0; m_irq = 1'b0; m_rsp_v = 1'b0; m_cnt = 0;
      m_btn_prev = btn;
      txq.delete(); rxq.delete();
      return;
    end
    m_irq   = ((rxq.size() != 0) && m_irq_en[2]) || ((txq.size() == 0) && m_irq_en[1]) ||
              ((m_evt != 0) && m_irq_en[0]);
    m_rsp_v = cmd_valid && !cmd_wr;
    if (m_rsp_v) m_rsp_d = model_read(cmd_addr);
    push_req = 1'b0;
    if (cmd_valid && cmd_wr) begin
      case (cmd_addr)
        6'd0: m_scratch = merge32(m_scratch, cmd_wdata, cmd_be);
        6'd1: push_req = 1'b1;
        6'd3: begin
          if (cmd_wdata[5]) m_txovf = 1'b0;
          if (cmd_wdata[4]) m_rxovf = 1'b0;
        end
        6'd4: begin t = merge32({28'b0, m_leds}, cmd_wdata, cmd_be); m_leds = t[3:0]; end
        6'd5: m_evt = m_evt & ~cmd_wdata[3:0];
        6'd7: if (cmd_be[0]) m_irq_en = cmd_wdata[2:0];
        6'd8, 6'd10: if (cmd_be[0]) m_color[(int'(cmd_addr) - 8) / 2] = cmd_wdata[2:0];
        6'd9, 6'd11: begin
          k = (int'(cmd_addr) - 9) / 2;
          t = merge32({16'b0, m_dcyc[k]}, cmd_wdata, cmd_be);
          m_dcyc[k] = t[15:0];
        end
        default: ;
      endcase
    end
    if (txq.size() > 0 && uart_tx_ready) void'(txq.pop_front());
    if (push_req) begin
      if (txq.size() < DEPTH) txq.push_back(cmd_wdata[7:0]);
      else m_txovf = 1'b1;
    end
    if (cmd_valid && !cmd_wr && cmd_addr == 6'd2 && rxq.size() > 0) void'(rxq.pop_front());
    if (uart_rx_valid) begin
      if (rxq.size() < DEPTH) rxq.push_back(uart_rx_data);
      else m_rxovf = 1'b1;
    end
    m_evt      = m_evt | (btn & ~m_btn_prev);
    m_btn_prev = btn;
    m_cnt      = (m_cnt + 1) % PER;
  endtask

  // One clock: advance model at the edge, compare every output shortly after it
  task automatic cycle();
    logic [5:0] exp_rgb;
    @(posedge clk);
    model_edge();
    #1;
    chk("rsp_valid", rsp_valid, m_rsp_v);
    if (m_rsp_v) chk("rsp_data", rsp_data, m_rsp_d);
    chk("leds", leds, m_leds);
    exp_rgb = '0;
    for (int k = 0; k < 2; k++) if (m_cnt < int'(m_dcyc[k])) exp_rgb[3*k +: 3] = m_color[k];
    chk("rgb", rgb, exp_rgb);
    chk("irq", irq, m_irq);
    chk("tx_valid", uart_tx_valid, txq.size() != 0);
    if (txq.size() != 0) chk("tx_data", uart_tx_data, txq[0]);
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = a; cmd_wdata = d; cmd_be = be;
    cycle();
    cmd_valid = 1'b0; cmd_wr = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, input logic [31:0] exp, input string tag);
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = a;
    cycle();
    cmd_valid = 1'b0;
    chk(tag, rsp_data, exp);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_on, n_odd, hold;
    logic rst_now;
    int r;
    reset = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_be = '0; btn = '0; sw = 4'ha; uart_tx_ready = 1'b0; uart_rx_data = '0;
    uart_rx_valid = 1'b0;
    repeat (3) cycle();
    chk("rst_leds", leds, 0);
    chk("rst_rgb", rgb, 0);
    chk("rst_irq", irq, 0);
    chk("rst_tx_valid", uart_tx_valid, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    reset = 1'b0;

    rd(6'd0, 32'h0, "scratch_rst");
    wr(6'd0, 32'hDEADBEEF, 4'b0101);
    rd(6'd0, 32'h00AD00EF, "scratch_be");

    // TX: 17 pushes with the transmitter stalled; byte enables do not matter here
    for (int i = 0; i < 17; i++) wr(6'd1, 32'h100 | (32'h10 + i), 4'h0);
    rd(6'd1, 32'd16, "tx_level_full");
    rd(6'd3, 32'h26, "status_tx_ovf");      // tx_ovf | rx_empty | tx_full
    uart_tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("tx_seq", uart_tx_data, 32'h10 + i);
      cycle();
    end
    uart_tx_ready = 1'b0;
    chk("tx_drained", uart_tx_valid, 0);
    rd(6'd3, 32'h25, "status_drained");
    wr(6'd3, 32'h20, 4'hf);
    rd(6'd3, 32'h05, "status_w1c");

    // RX
    uart_rx_valid = 1'b1; uart_rx_data = 8'h41; cycle();
    uart_rx_data = 8'h42; cycle();
    uart_rx_valid = 1'b0;
    rd(6'd2, 32'h80000041, "rx_first");
    rd(6'd2, 32'h80000042, "rx_second");
    rd(6'd2, 32'h0, "rx_empty_read");
    uart_rx_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin uart_rx_data = 8'(8'h60 + i); cycle(); end
    uart_rx_valid = 1'b0;
    rd(6'd3, 32'h09, "status_rx_full");
    uart_rx_valid = 1'b1; uart_rx_data = 8'h99;
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 6'd2;
    cycle();
    uart_rx_valid = 1'b0; cmd_valid = 1'b0;
    chk("rx_pushpop_data", rsp_data, 32'h80000060);
    rd(6'd3, 32'h09, "status_no_rx_ovf");
    for (int i = 1; i < 16; i++) rd(6'd2, 32'h80000060 + i, "rx_drain");
    rd(6'd2, 32'h80000099, "rx_pushed_while_full");

    // Buttons and interrupt
    btn = 4'b0100; cycle();
    btn = 4'b0000; cycle();
    rd(6'd5, 32'h4, "btn_evt");
    wr(6'd7, 32'h1, 4'h1);
    cycle();
    chk("irq_btn", irq, 1);
    btn = 4'b0100;
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 6'd5; cmd_wdata = 32'h4; cmd_be = 4'hf;
    cycle();
    cmd_valid = 1'b0; cmd_wr = 1'b0; btn = 4'b0000;
    rd(6'd5, 32'h4, "btn_evt_set_wins");
    wr(6'd5, 32'h4, 4'hf);
    rd(6'd5, 32'h0, "btn_evt_clr");
    cycle();
    chk("irq_clr", irq, 0);
    wr(6'd7, 32'h0, 4'hf);

    // PWM on channel 1
    wr(6'd10, 32'h5, 4'hf);
    wr(6'd11, 32'd8, 4'hf);
    n_on = 0; n_odd = 0;
    repeat (64) begin
      cycle();
      if (rgb[5:3] == 3'b101) n_on++; else if (rgb[5:3] != 3'b000) n_odd++;
    end
    chk("pwm_dc8_on", n_on, 16);
    chk("pwm_dc8_other", n_odd, 0);
    wr(6'd11, 32'd40, 4'hf);
    n_on = 0;
    repeat (32) begin cycle(); if (rgb[5:3] == 3'b101) n_on++; end
    chk("pwm_dc40_on", n_on, 32);
    wr(6'd11, 32'd0, 4'hf);
    n_on = 0;
    repeat (32) begin cycle(); if (rgb[5:3] != 3'b000) n_on++; end
    chk("pwm_dc0_on", n_on, 0);

    rd(6'd63, 32'h0, "unmapped_63");

    // Reset with TX bytes pending and a read in the reset cycle
    for (int i = 0; i < 5; i++) wr(6'd1, 32'hA0 + i, 4'hf);
    rd(6'd1, 32'd5, "tx_level5");
    reset = 1'b1; cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 6'd0;
    cycle();
    cmd_valid = 1'b0;
    chk("midrst_tx_valid", uart_tx_valid, 0);
    chk("midrst_no_rsp", rsp_valid, 0);
    reset = 1'b0;
    rd(6'd3, 32'h05, "status_after_rst");

    // Randomized traffic
    hold = 0;
    for (int n = 0; n < 3000; n++) begin
      rst_now = ($urandom_range(0, 399) == 0);
      if (!rst_now && hold == 0 && $urandom_range(0, 99) < 15) btn = 4'($urandom);
      if (hold > 0) hold--;
      if (rst_now) hold = 1;
      reset         = rst_now;
      sw            = 4'($urandom);
      uart_tx_ready = ($urandom_range(0, 99) < 30);
      uart_rx_valid = ($urandom_range(0, 99) < 40);
      uart_rx_data  = 8'($urandom);
      cmd_valid     = ($urandom_range(0, 99) < 70);
      cmd_wr        = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 19);
      if (r < 12) cmd_addr = 6'(r);
      else if (r < 16) cmd_addr = 6'd2;
      else if (r == 16) cmd_addr = 6'd63;
      else cmd_addr = 6'($urandom);
      cmd_wdata = $urandom;
      if ((cmd_addr == 6'd9 || cmd_addr == 6'd11) && $urandom_range(0, 1) == 1)
        cmd_wdata = cmd_wdata & 32'h3f;
      cmd_be = 4'($urandom);
      cycle();
    end
    reset = 1'b0; cmd_valid = 1'b0; uart_rx_valid = 1'b0;
    repeat (4) cycle();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
